// File: rtl/alu_seq_pkg.sv
// ============================================================================
// Module      : alu_seq_pkg
// Description : Shared state encoding and opcode constants for the multi-byte
//               ALU chain sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_seq_pkg;

  // Sequencer states. The width is explicit so the register width is fixed.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_EXEC = 3'd2,
    ST_EMIT = 3'd3,
    ST_DONE = 3'd4
  } seq_state_e;

  // ALU opcodes. These values go straight onto the ALU ALUControl port.
  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_SUB = 2'b11;

endpackage : alu_seq_pkg

`default_nettype wire

// File: rtl/alu_seq_status.sv
// ============================================================================
// Module      : alu_seq_status
// Description : Carry/borrow chain register, whole-word zero accumulator and
//               the final status outputs of the ALU chain sequencer.
//               Optional signed-overflow status under ALU_SEQ_OVF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_seq_status
  import alu_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,       // start of a new word operation
  input  logic       exec_en,     // one byte is being computed this cycle
  input  logic       commit,      // last byte handed over; publish status
  input  logic [1:0] op,
  input  logic       alu_flags,
  input  logic [7:0] alu_result,
`ifdef ALU_SEQ_OVF_EN
  input  logic       a_msb,       // MSB of the most recent operand A byte
  input  logic       b_msb,       // MSB of the most recent operand B byte
  input  logic       r_msb,       // MSB of the most recent result byte
  output logic       ovf_out,
`endif
  output logic       carry,       // chained carry/borrow into the ALU
  output logic       carry_out,
  output logic       zero_out
);

  logic r_carry;
  logic r_zero_acc;
  logic w_arith;

  // Only ADD and SUB drive a meaningful flag from the ALU.
  assign w_arith = (op == OP_ADD) || (op == OP_SUB);
  assign carry   = r_carry;

  // Per-byte chain state: carry/borrow and running all-zero flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_carry    <= 1'b0;
      r_zero_acc <= 1'b0;
    end else if (clear) begin
      r_carry    <= 1'b0;
      r_zero_acc <= 1'b1;
    end else if (exec_en) begin
      r_carry    <= w_arith ? alu_flags : 1'b0;
      r_zero_acc <= r_zero_acc & (alu_result == 8'h00);
    end
  end

  // Publish final status when the last byte leaves; held until the next word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_out <= 1'b0;
      zero_out  <= 1'b0;
    end else if (commit) begin
      carry_out <= r_carry;
      zero_out  <= r_zero_acc;
    end
  end

`ifdef ALU_SEQ_OVF_EN
  logic w_ovf;

  // Two's-complement overflow from the top byte: ADD overflows when the
  // operand signs agree and the result sign differs; SUB when they disagree.
  always_comb begin
    w_ovf = 1'b0;
    if (op == OP_ADD) begin
      w_ovf = (a_msb == b_msb) && (r_msb != a_msb);
    end else if (op == OP_SUB) begin
      w_ovf = (a_msb != b_msb) && (r_msb != a_msb);
    end
  end

  // Overflow status published together with carry/zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_out <= 1'b0;
    end else if (commit) begin
      ovf_out <= w_ovf;
    end
  end
`endif

endmodule : alu_seq_status

`default_nettype wire

// File: rtl/alu_chain_sequencer.sv
// ============================================================================
// Module      : alu_chain_sequencer
// Description : Streams NBYTES operand byte pairs (LSB first) through an
//               external combinational 8-bit ALU, chaining carry/borrow, and
//               emits each result byte over a valid/ready handshake.
//               Optional feature macro: ALU_SEQ_OVF_EN (adds ovf_out).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_chain_sequencer
  import alu_seq_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] op,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_a,
  input  logic [7:0] in_b,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [1:0] alu_control,
  output logic       alu_flag_in,
  input  logic [7:0] alu_result,
  input  logic       alu_flags,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       busy,
  output logic       done,
  output logic       carry_out,
  output logic       zero_out
`ifdef ALU_SEQ_OVF_EN
  ,
  output logic       ovf_out
`endif
);

  localparam int c_cnt_w = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(NBYTES - 1);

  seq_state_e         r_state;
  seq_state_e         w_state_next;
  logic [1:0]         r_op;
  logic [7:0]         r_op_a;
  logic [7:0]         r_op_b;
  logic [7:0]         r_result;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_in_ready;
  logic               r_out_valid;
  logic               r_busy;
  logic               r_done;

  logic w_start_acc;
  logic w_load_acc;
  logic w_exec;
  logic w_emit_acc;
  logic w_last;
  logic w_carry;

  // ALU is fed straight from registers so its path is purely combinational
  // inside the EXEC cycle.
  assign alu_a       = r_op_a;
  assign alu_b       = r_op_b;
  assign alu_control = r_op;
  assign alu_flag_in = w_carry;
  assign out_data    = r_result;
  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign busy        = r_busy;
  assign done        = r_done;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and per-cycle control strobes.
  always_comb begin
    w_state_next = r_state;
    w_start_acc  = 1'b0;
    w_load_acc   = 1'b0;
    w_exec       = 1'b0;
    w_emit_acc   = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_start_acc  = 1'b1;
          w_state_next = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (in_valid && r_in_ready) begin
          w_load_acc   = 1'b1;
          w_state_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        w_exec       = 1'b1;
        w_state_next = ST_EMIT;
      end
      ST_EMIT: begin
        if (out_ready) begin
          w_emit_acc = 1'b1;
          if (r_cnt == c_last) begin
            w_last       = 1'b1;
            w_state_next = ST_DONE;
          end else begin
            w_state_next = ST_LOAD;
          end
        end
      end
      ST_DONE: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Handshake/status outputs registered from the upcoming state so they line
  // up exactly with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_in_ready  <= (w_state_next == ST_LOAD);
      r_out_valid <= (w_state_next == ST_EMIT);
      r_busy      <= (w_state_next != ST_IDLE);
      r_done      <= (w_state_next == ST_DONE);
    end
  end

  // Opcode, operand, result and byte-counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op     <= 2'b00;
      r_op_a   <= 8'h00;
      r_op_b   <= 8'h00;
      r_result <= 8'h00;
      r_cnt    <= '0;
    end else begin
      if (w_start_acc) begin
        r_op  <= op;
        r_cnt <= '0;
      end
      if (w_load_acc) begin
        r_op_a <= in_a;
        r_op_b <= in_b;
      end
      if (w_exec) begin
        r_result <= alu_result;
      end
      if (w_emit_acc && !w_last) begin
        r_cnt <= r_cnt + c_cnt_w'(1);
      end
    end
  end

  alu_seq_status u_status (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (w_start_acc),
    .exec_en    (w_exec),
    .commit     (w_last),
    .op         (r_op),
    .alu_flags  (alu_flags),
    .alu_result (alu_result),
`ifdef ALU_SEQ_OVF_EN
    .a_msb      (r_op_a[7]),
    .b_msb      (r_op_b[7]),
    .r_msb      (r_result[7]),
    .ovf_out    (ovf_out),
`endif
    .carry      (w_carry),
    .carry_out  (carry_out),
    .zero_out   (zero_out)
  );

endmodule : alu_chain_sequencer

`default_nettype wire

// File: tb/tb_alu_chain_sequencer.sv
// ============================================================================
// Module      : tb_alu_chain_sequencer
// Description : Directed self-checking bench for alu_chain_sequencer with a
//               behavioural 8-bit ALU closing the loop.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_chain_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [1:0] op;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [1:0] alu_control;
  logic       alu_flag_in;
  logic [7:0] alu_result;
  logic       alu_flags;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       busy;
  logic       done;
  logic       carry_out;
  logic       zero_out;
`ifdef ALU_SEQ_OVF_EN
  logic       ovf_out;
`endif

  logic [31:0] tb_a;
  logic [31:0] tb_b;
  logic [1:0]  bidx;
  logic [8:0]  alu_tmp;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  assign in_a = tb_a[8*bidx +: 8];
  assign in_b = tb_b[8*bidx +: 8];

  // Behavioural ALU. AND/OR deliberately drive flag=1 so any use of it by the
  // sequencer for logic ops would corrupt carry_out.
  always_comb begin
    alu_tmp    = 9'h000;
    alu_result = 8'h00;
    alu_flags  = 1'b0;
    case (alu_control)
      2'b00: begin alu_result = alu_a & alu_b; alu_flags = 1'b1; end
      2'b01: begin alu_result = alu_a | alu_b; alu_flags = 1'b1; end
      2'b10: begin
        alu_tmp    = {1'b0, alu_a} + {1'b0, alu_b} + {8'h00, alu_flag_in};
        alu_result = alu_tmp[7:0];
        alu_flags  = alu_tmp[8];
      end
      default: begin
        alu_tmp    = {1'b0, alu_a} - {1'b0, alu_b} - {8'h00, alu_flag_in};
        alu_result = alu_tmp[7:0];
        alu_flags  = alu_tmp[8];
      end
    endcase
  end

  alu_chain_sequencer #(.NBYTES(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .op          (op),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_control (alu_control),
    .alu_flag_in (alu_flag_in),
    .alu_result  (alu_result),
    .alu_flags   (alu_flags),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .busy        (busy),
    .done        (done),
    .carry_out   (carry_out),
    .zero_out    (zero_out)
`ifdef ALU_SEQ_OVF_EN
    ,
    .ovf_out     (ovf_out)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Runs one word operation starting just after a clock edge while IDLE.
  task automatic run_op(input string tag, input logic [1:0] o,
                        input logic [31:0] a, input logic [31:0] b,
                        input int stall, input logic [31:0] exp_word,
                        input logic exp_c, input logic exp_z,
                        input int exp_done, input logic chk_flag);
    int          k;
    int          n;
    int          stall_left;
    int          done_cyc;
    logic [31:0] got;
    logic        take;
    logic        flag_seen;
    start    = 1'b1;
    op       = o;
    tb_a     = a;
    tb_b     = b;
    bidx     = 2'd0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    start      = 1'b0;
    k          = 1;
    n          = 0;
    got        = 32'h0;
    done_cyc   = -1;
    stall_left = stall;
    flag_seen  = 1'b0;
    while (k < 300 && done_cyc < 0) begin
      if (alu_flag_in) flag_seen = 1'b1;
      if (done) done_cyc = k;
      if (out_valid && n == 1 && stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
        check({tag, "_stall_data"}, out_data, exp_word[15:8]);
        check({tag, "_stall_in_ready"}, in_ready, 1'b0);
      end else begin
        out_ready = 1'b1;
        if (out_valid && n < 4) begin
          got[8*n +: 8] = out_data;
          n++;
        end
      end
      take = in_valid && in_ready;
      if (done_cyc < 0) begin
        @(posedge clk); #1;
        k++;
        if (take) bidx = bidx + 2'd1;
      end
    end
    check({tag, "_done_cycle"}, done_cyc, exp_done);
    check({tag, "_word"}, got, exp_word);
    if (chk_flag) check({tag, "_flag_in"}, flag_seen, 1'b0);
    @(posedge clk); #1;
    check({tag, "_busy_idle"}, busy, 1'b0);
    check({tag, "_carry"}, carry_out, exp_c);
    check({tag, "_zero"}, zero_out, exp_z);
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    op        = 2'b00;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    tb_a      = 32'h0;
    tb_b      = 32'h0;
    bidx      = 2'd0;
    #12;
    check("reset_outputs",
          {in_ready, out_valid, out_data, alu_a, alu_b, alu_control,
           alu_flag_in, busy, done, carry_out, zero_out}, 64'h0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("add_ff_1",   2'b10, 32'h000000FF, 32'h00000001, 0, 32'h00000100, 1'b0, 1'b0, 13, 1'b0);
    run_op("add_stall",  2'b10, 32'h000000FF, 32'h00000001, 5, 32'h00000100, 1'b0, 1'b0, 18, 1'b0);
    run_op("sub_0_1",    2'b11, 32'h00000000, 32'h00000001, 0, 32'hFFFFFFFF, 1'b1, 1'b0, 13, 1'b0);
    run_op("add_wrap",   2'b10, 32'hFFFFFFFF, 32'h00000001, 0, 32'h00000000, 1'b1, 1'b1, 13, 1'b0);
    run_op("or_mix",     2'b01, 32'h12345678, 32'h00FF0000, 0, 32'h12FF5678, 1'b0, 1'b0, 13, 1'b1);
    run_op("and_zero",   2'b00, 32'hF0F0F0F0, 32'h0F0F0F0F, 0, 32'h00000000, 1'b0, 1'b1, 13, 1'b1);

    // Reset during EXEC of byte 2 (cycle 8).
    start    = 1'b1;
    op       = 2'b10;
    tb_a     = 32'h44332211;
    tb_b     = 32'h01010101;
    bidx     = 2'd0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k < 8; k++) begin
      logic take;
      take = in_valid && in_ready;
      @(posedge clk); #1;
      if (take) bidx = bidx + 2'd1;
    end
    check("midop_busy", busy, 1'b1);
    check("midop_alu_a_byte2", alu_a, 8'h33);
    rst_n = 1'b0;
    #1;
    check("midop_reset_outputs",
          {in_ready, out_valid, out_data, alu_a, alu_b, alu_control,
           alu_flag_in, busy, done, carry_out, zero_out}, 64'h0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    run_op("add_1_1", 2'b10, 32'h00000001, 32'h00000001, 0, 32'h00000002, 1'b0, 1'b0, 13, 1'b0);

`ifdef ALU_SEQ_OVF_EN
    run_op("add_ovf", 2'b10, 32'h7FFFFFFF, 32'h00000001, 0, 32'h80000000, 1'b0, 1'b0, 13, 1'b0);
    check("add_ovf_flag", ovf_out, 1'b1);
    run_op("sub_noovf", 2'b11, 32'h00000005, 32'h00000003, 0, 32'h00000002, 1'b0, 1'b0, 13, 1'b0);
    check("sub_noovf_flag", ovf_out, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_alu_chain_sequencer

`default_nettype wire
